// File: rtl/gate_matrix_loader.sv
// Serial row-major gate-matrix loader: shadow-buffers one frame, then atomically commits it to the gate array.
// Optional IDENTITY_ON_RESET_EN: reset loads gate with the identity matrix instead of zeros.
module gate_matrix_loader #(
  parameter int SIZE = 8,
  parameter int N    = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] in_data,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  output logic [SIZE-1:0] gate [(1<<N)-1:0][(1<<N)-1:0],
  output logic            gate_valid,
  input  logic            gate_ack,
  output logic            frame_err
);
  localparam int DIM = 1 << N;
  localparam int CW  = 2 * N;
  localparam logic [CW-1:0] LAST_IDX = '1;
`ifdef IDENTITY_ON_RESET_EN
  localparam logic [SIZE-1:0] ONE = SIZE'(1) << (SIZE - 2);
`endif

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [SIZE-1:0] r_shadow [DIM][DIM];
  logic            r_gate_valid, r_frame_err;
  logic            w_xfer, w_term, w_commit, w_err, w_ack;

  assign in_ready   = reset & (r_state != HOLD);
  assign w_xfer     = in_valid & in_ready;
  assign w_term     = (r_cnt == LAST_IDX);
  assign w_ack      = (r_state == HOLD) & gate_ack;
  assign gate_valid = r_gate_valid;
  assign frame_err  = r_frame_err;

  // in_last must coincide exactly with the terminal element; any disagreement drops the frame.
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE, LOAD: begin
        if (w_xfer) begin
          if (in_last != w_term) begin
            w_err       = 1'b1;
            w_state_nxt = IDLE;
          end else if (w_term) begin
            w_commit    = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_state_nxt = LOAD;
          end
        end
      end
      HOLD:    if (gate_ack) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt        <= '0;
      r_gate_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_err <= w_err;
      if (w_err || w_commit || w_ack) r_cnt <= '0;
      else if (w_xfer)                r_cnt <= r_cnt + 1'b1;
      if (w_commit)                      r_gate_valid <= 1'b1;
      else if (r_gate_valid && gate_ack) r_gate_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++)
          r_shadow[r][c] <= '0;
    end else if (w_xfer && !w_err) begin
      r_shadow[r_cnt[CW-1:N]][r_cnt[N-1:0]] <= in_data;
    end
  end

  // The terminal element is always [DIM-1][DIM-1]; take it straight from the input on commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++)
`ifdef IDENTITY_ON_RESET_EN
          gate[r][c] <= (r == c) ? ONE : '0;
`else
          gate[r][c] <= '0;
`endif
    end else if (w_commit) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++)
          gate[r][c] <= (r == DIM-1 && c == DIM-1) ? in_data : r_shadow[r][c];
    end
  end

endmodule
